imm_lut_encoder: RTL and testbench
==================================

# imm_lut_encoder

Reverse-lookup companion to the immediate/branch-target LUT: a 16-entry, 8-bit, software-loadable table that answers "which 4-bit index produces this value?". The assembler-support path and the debug controller use it to turn a desired immediate or absolute branch target into the 4-bit field an instruction carries. It also exposes the forward read (index to value) for consistency checking. Searches are sequential, one entry per cycle, and use a valid/ready handshake on both request and response.

## Interface
- `PC_width`, 8: entry width in bits, matching the immediate/target width.
- `Clk`  in  1: single clock; all state updates on its rising edge.
- `Reset`  in  1: synchronous, active-high; restores the table and returns to IDLE.
- `wr_en`  in  1: write strobe; acts only while `wr_ready` = 1.
- `wr_addr`  in  4: entry to write.
- `wr_data`  in  PC_width: value to write.
- `wr_ready`  out  1: 1 only in IDLE.
- `rd_addr`  in  4: forward-read index.
- `rd_data`  out  PC_width: combinational `table[rd_addr]`.
- `req_valid`  in  1: search request.
- `req_value`  in  PC_width: value to search for; captured on acceptance.
- `req_ready`  out  1: 1 only in IDLE.
- `resp_valid`  out  1: result available; 1 only in DONE.
- `resp_ready`  in  1: consumer accepts the result.
- `resp_hit`  out  1: 1 if a match was found.
- `resp_index`  out  4: lowest matching index on a hit; 4'hF on a miss.

## Operation
- Reset contents, entries 0 to 15: 34, 01, 34, 40, 07, 16, 22, 07, 37, 4A, 56, 68, 72, 7E, 8B, 01 (hex).
- Reset values: state IDLE, `resp_valid`=0, `resp_hit`=0, `resp_index`=0, internal scan counter 0, captured key 0.
- **Writes**
  - With `wr_en && wr_ready`, `table[wr_addr] <= wr_data` at the clock edge.
  - `wr_en` is ignored in SCAN and DONE. No write is queued.
- **State machine**
  - IDLE: `req_ready`=1. On `req_valid`: capture `req_value`, set the counter to 0, go to SCAN.
  - SCAN: each cycle, compare `table[counter]` with the captured key.
    - Match: record `resp_hit`=1 and `resp_index`=counter, go to DONE.
    - No match and counter = 15: record `resp_hit`=0 and `resp_index`=4'hF, go to DONE.
    - Otherwise: increment the counter and stay in SCAN.
  - DONE: `resp_valid`=1, with `resp_hit` and `resp_index` held stable. On `resp_ready`, go to IDLE. `resp_hit` and `resp_index` keep their values until the next result is recorded.
- **Duplicate values**: the lowest index wins (e.g. 0x34 returns index 0, never 2).
- **Width rule**: comparison is exact equality over all `PC_width` bits. There is no sign or zero extension.

## Timing
- Request accepted at edge N: entry k is compared in the cycle after edge N+k, and `resp_valid` rises after edge N+1+k.
  - Best case (k=0): `resp_valid` asserts 2 cycles after the request is presented.
  - Worst case (hit at index 15, or a miss): 17 cycles.
- A result held in DONE stays stable indefinitely while `resp_ready`=0 (backpressure).
- **Simultaneous `wr_en` and `req_valid` in IDLE**: both take effect at the same edge. The scan sees the newly written value.
- **`resp_ready` with `resp_valid` at edge M**: the block is in IDLE after M.
  - A new request can be accepted at edge M+1.
  - Back-to-back throughput is one search per (k+3) cycles.
- `rd_data` is purely combinational from the table and `rd_addr` in every state. A write is visible on the cycle after its edge.
- **`Reset` in any state**, including mid-SCAN and DONE:
  - The next edge restores the table and goes to IDLE with `resp_valid`=0.
  - The in-flight search is discarded and no response is produced.
- `req_valid` or `wr_en` asserted in the same cycle as `Reset` is ignored.

## Test plan
- Reset, then forward-read all 16 indices: `rd_data` matches the reset contents (index 3 → 0x40, index 14 → 0x8B, index 15 → 0x01).
- Search 0x34: `resp_hit`=1, `resp_index`=0, `resp_valid` 2 cycles after the request. Search 0x07: `resp_index`=4. Search 0x8B: `resp_index`=14.
- Search 0xFF: `resp_hit`=0, `resp_index`=F, latency 17. Hold `resp_ready`=0 for 5 cycles: the outputs stay stable and `req_ready`=0.
- In IDLE, write `table[15]`=0xAA in the same cycle as a request for 0xAA: hit at index 15. Then assert `wr_en` (entry 0 ← 0x00) during a scan: `table[0]` is still 0x34.
- Assert `Reset` at SCAN cycle 5 of a 0x8B search: the next cycle has `resp_valid`=0 and `req_ready`=1. Any earlier writes are reverted to the reset contents.
- Write 0x34 into entry 1, then search 0x34: index 0 is returned (lowest wins). Write 0x00 to entry 0 and search again: index 1.

Source files
------------

// File: rtl/imm_lut_encoder.sv
// Reverse-lookup table: 16 software-loadable entries searched one per cycle for the lowest
// index that holds a requested value; also offers a combinational forward read.
module imm_lut_encoder #(
    parameter int PC_width = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [PC_width-1:0] wr_data,
    output logic                wr_ready,
    input  logic [3:0]          rd_addr,
    output logic [PC_width-1:0] rd_data,
    input  logic                req_valid,
    input  logic [PC_width-1:0] req_value,
    output logic                req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic [3:0]          resp_index
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state, state_next;
    logic [PC_width-1:0] lut [16];
    logic [PC_width-1:0] key;
    logic [3:0]          counter;
    logic                match;

    function automatic logic [PC_width-1:0] reset_entry(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd0:    v = 8'h34;
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h34;
            4'd3:    v = 8'h40;
            4'd4:    v = 8'h07;
            4'd5:    v = 8'h16;
            4'd6:    v = 8'h22;
            4'd7:    v = 8'h07;
            4'd8:    v = 8'h37;
            4'd9:    v = 8'h4A;
            4'd10:   v = 8'h56;
            4'd11:   v = 8'h68;
            4'd12:   v = 8'h72;
            4'd13:   v = 8'h7E;
            4'd14:   v = 8'h8B;
            default: v = 8'h01;
        endcase
        return PC_width'(v);
    endfunction

    assign rd_data = lut[rd_addr];
    assign match   = (lut[counter] == key);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            key        <= '0;
            counter    <= '0;
            resp_hit   <= 1'b0;
            resp_index <= 4'h0;
            for (int i = 0; i < 16; i++) begin
                lut[i] <= reset_entry(4'(i));
            end
        end else begin
            state <= state_next;
            // Writes only land in IDLE, so a running scan always sees a frozen table.
            if (wr_en && state == IDLE) begin
                lut[wr_addr] <= wr_data;
            end
            if (state == IDLE && req_valid) begin
                key     <= req_value;
                counter <= 4'h0;
            end
            if (state == SCAN) begin
                if (match) begin
                    resp_hit   <= 1'b1;
                    resp_index <= counter;
                end else if (counter == 4'hF) begin
                    resp_hit   <= 1'b0;
                    resp_index <= 4'hF;
                end else begin
                    counter <= counter + 4'h1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                wr_ready  = 1'b1;
                req_ready = 1'b1;
                if (req_valid) state_next = SCAN;
            end
            SCAN: begin
                if (match || counter == 4'hF) state_next = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imm_lut_encoder.sv
// Directed bench for imm_lut_encoder: expected search results are queued at issue time and
// popped by an independent monitor whenever a response appears.
module tb_imm_lut_encoder;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       req_valid;
    logic [7:0] req_value;
    logic       req_ready;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_hit;
    logic [3:0] resp_index;

    imm_lut_encoder #(.PC_width(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .req_valid(req_valid), .req_value(req_value), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_index(resp_index)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       hit;
        logic [3:0] idx;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         t_present = 0;
    logic       seen     = 1'b0;
    logic [7:0] rst_tbl [16];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: one pop per response, on the first cycle resp_valid is seen.
    always @(negedge Clk) begin
        if (resp_valid && !seen) begin
            exp_t e;
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                flag("unexpected_response");
            end else begin
                e = exp_q.pop_front();
                check("resp_hit", 32'(resp_hit), 32'(e.hit));
                check("resp_index", 32'(resp_index), 32'(e.idx));
                check("latency", 32'(cyc - t_present), 32'(e.lat));
            end
        end
        if (!resp_valid) seen = 1'b0;
    end

    // All main-thread tasks start and end just after a falling edge.
    task automatic issue(input logic [7:0] v, input logic push, input logic hit,
                         input logic [3:0] idx, input int lat);
        exp_t e;
        if (push) begin
            e.hit = hit; e.idx = idx; e.lat = lat;
            exp_q.push_back(e);
        end
        check("req_ready_at_issue", 32'(req_ready), 32'd1);
        req_value = v;
        req_valid = 1'b1;
        t_present = cyc;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic wait_resp();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (resp_valid) break;
        end
        if (i == 40) flag("response_timeout");
    endtask

    task automatic search(input logic [7:0] v, input logic hit, input logic [3:0] idx,
                          input int lat);
        issue(v, 1'b1, hit, idx, lat);
        wait_resp();
        @(negedge Clk);
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge Clk);
        #1;
        wr_en = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        rst_tbl = '{8'h34, 8'h01, 8'h34, 8'h40, 8'h07, 8'h16, 8'h22, 8'h07,
                    8'h37, 8'h4A, 8'h56, 8'h68, 8'h72, 8'h7E, 8'h8B, 8'h01};
        Reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        req_valid = 1'b0; req_value = '0; resp_ready = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_hit", 32'(resp_hit), 32'd0);
        check("rst_resp_index", 32'(resp_index), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(rst_tbl[i]));
        end
        @(negedge Clk);

        search(8'h34, 1'b1, 4'd0, 2);
        search(8'h07, 1'b1, 4'd4, 6);
        search(8'h8B, 1'b1, 4'd14, 16);

        // Miss under backpressure
        resp_ready = 1'b0;
        issue(8'hFF, 1'b1, 1'b0, 4'hF, 17);
        wait_resp();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_hit", 32'(resp_hit), 32'd0);
            check("bp_resp_index", 32'(resp_index), 32'hF);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge Clk);
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_req_ready", 32'(req_ready), 32'd1);

        // Write and request at the same edge: scan sees the new entry
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'hAA;
        search(8'hAA, 1'b1, 4'd15, 17);

        // Write attempted during a scan is dropped
        issue(8'h8B, 1'b1, 1'b1, 4'd14, 16);
        @(negedge Clk);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h00;
        check("wr_ready_in_scan", 32'(wr_ready), 32'd0);
        wait_resp();
        wr_en = 1'b0;
        @(negedge Clk);
        rd_addr = 4'd0;
        #1;
        check("scan_write_dropped", 32'(rd_data), 32'h34);

        // Reset mid-scan reverts writes and discards the search
        write(4'd5, 8'h99);
        rd_addr = 4'd5;
        #1;
        check("write_visible", 32'(rd_data), 32'h99);
        issue(8'h8B, 1'b0, 1'b0, 4'h0, 0);
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        req_valid = 1'b1; req_value = 8'h34;
        @(negedge Clk);
        Reset = 1'b0;
        req_valid = 1'b0;
        check("midscan_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("midscan_rst_req_ready", 32'(req_ready), 32'd1);
        rd_addr = 4'd5;
        #1;
        check("revert_entry5", 32'(rd_data), 32'h16);
        rd_addr = 4'd15;
        #1;
        check("revert_entry15", 32'(rd_data), 32'h01);
        repeat (20) @(negedge Clk);
        check("no_resp_after_reset", 32'(exp_q.size()), 32'd0);

        // Duplicates: lowest index wins
        write(4'd1, 8'h34);
        search(8'h34, 1'b1, 4'd0, 2);
        write(4'd0, 8'h00);
        search(8'h34, 1'b1, 4'd1, 3);

        repeat (2) @(negedge Clk);
        if (exp_q.size() != 0) flag("responses_missing");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
